// File: rtl/ps2_scan_decoder.sv
// PS/2 scan-code prefix decoder: turns raw set-2 bytes into make/break events
// in a first-word-fall-through FIFO and tracks the state of the shift keys.
module ps2_scan_decoder #(
    parameter int unsigned DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] code,
    input  logic       tick,
    input  logic       correct,
    input  logic       rd_en,
    output logic [9:0] ev_data,
    output logic       ev_valid,
    output logic       shift_held,
    output logic       frame_err,
    output logic       overflow
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {StIdle, StExt, StBrk, StExtBrk} state_e;

    state_e        state_q, state_d;
    logic          push, push_rel, push_ext;
    logic [9:0]    push_data;
    logic          ferr_d, frame_err_q;
    logic          lshift_q, lshift_d, rshift_q, rshift_d;
    logic          is_prefix, is_ignored;
    logic          full, do_push, do_pop;
    logic [9:0]    mem_q [DEPTH];
    logic [AW-1:0] rd_ptr_q, wr_ptr_q;
    logic [CW-1:0] count_q;
    logic          overflow_q;

    assign is_prefix  = (code == 8'hE0) || (code == 8'hF0);
    // Keyboard housekeeping replies that never carry key information
    assign is_ignored = (code == 8'h00) || (code == 8'hAA) || (code == 8'hEE) ||
                        (code == 8'hFA) || (code == 8'hFC) || (code == 8'hFE) ||
                        (code == 8'hFF);

    always_comb begin
        state_d  = state_q;
        push     = 1'b0;
        push_rel = 1'b0;
        push_ext = 1'b0;
        ferr_d   = 1'b0;
        if (tick) begin
            if (!correct) begin
                state_d = StIdle;
                ferr_d  = 1'b1;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        if (code == 8'hE0)      state_d = StExt;
                        else if (code == 8'hF0) state_d = StBrk;
                        else if (!is_ignored)   push = 1'b1;
                    end
                    StExt: begin
                        if (code == 8'hF0) begin
                            state_d = StExtBrk;
                        end else if (code != 8'hE0) begin
                            push     = 1'b1;
                            push_ext = 1'b1;
                            state_d  = StIdle;
                        end
                    end
                    StBrk: begin
                        state_d  = StIdle;
                        push     = !is_prefix;
                        push_rel = 1'b1;
                    end
                    StExtBrk: begin
                        state_d  = StIdle;
                        push     = !is_prefix;
                        push_rel = 1'b1;
                        push_ext = 1'b1;
                    end
                    default: state_d = StIdle;
                endcase
            end
        end
    end

    assign push_data = {push_rel, push_ext, code};

    // Fake shifts (E0 12 / E0 59) are ignored; dropped pushes still update tracking
    always_comb begin
        lshift_d = lshift_q;
        rshift_d = rshift_q;
        if (push && !push_ext) begin
            if (code == 8'h12) lshift_d = !push_rel;
            if (code == 8'h59) rshift_d = !push_rel;
        end
    end

    assign full    = (count_q == CW'(DEPTH));
    assign do_pop  = !rst && rd_en && (count_q != '0);
    assign do_push = !rst && push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            frame_err_q <= 1'b0;
            lshift_q    <= 1'b0;
            rshift_q    <= 1'b0;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            frame_err_q <= ferr_d;
            lshift_q    <= lshift_d;
            rshift_q    <= rshift_d;
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            if (do_push && !do_pop)      count_q <= count_q + CW'(1);
            else if (do_pop && !do_push) count_q <= count_q - CW'(1);
            if (push && full && !do_pop) overflow_q <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data;
    end

    assign ev_valid   = (count_q != '0);
    assign ev_data    = ev_valid ? mem_q[rd_ptr_q] : '0;
    assign shift_held = lshift_q | rshift_q;
    assign frame_err  = frame_err_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_ps2_scan_decoder.sv
// Directed bench for ps2_scan_decoder: a table of per-cycle vectors with
// hand-computed expectations, plus a FIFO pointer-wrap sequence.
module tb_ps2_scan_decoder;

    logic       clk = 1'b0;
    logic       rst, tick, correct, rd_en;
    logic [7:0] code;
    logic [9:0] ev_data;
    logic       ev_valid, shift_held, frame_err, overflow;

    int checks = 0;
    int errors = 0;

    ps2_scan_decoder #(.DEPTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .code      (code),
        .tick      (tick),
        .correct   (correct),
        .rd_en     (rd_en),
        .ev_data   (ev_data),
        .ev_valid  (ev_valid),
        .shift_held(shift_held),
        .frame_err (frame_err),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       r, t;
        logic [7:0] c;
        logic       co, rd;
        logic       v;
        logic [9:0] d;
        logic       cd, sh, fe, ov;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic t, input logic [7:0] c, input logic co,
                       input logic rd, input logic v, input logic [9:0] d, input logic sh,
                       input logic fe, input logic ov);
        vec_t x;
        x.r = r; x.t = t; x.c = c; x.co = co; x.rd = rd;
        x.v = v; x.d = d; x.cd = v | r; x.sh = sh; x.fe = fe; x.ov = ov;
        vecs.push_back(x);
    endtask

    task automatic chk(input string name, input int idx, input logic [9:0] act,
                       input logic [9:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @vec %0d: got %h, expected %h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic t, input logic [7:0] c, input logic co,
                         input logic rd);
        rst = r; tick = t; code = c; correct = co; rd_en = rd;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; tick = 1'b0; code = 8'h00; correct = 1'b1; rd_en = 1'b0;

        //  r  t  code   co rd  v  data     sh fe ov
        add(1, 0, 8'h00, 1, 0, 0, 10'h000, 0, 0, 0);  // reset
        add(0, 0, 8'h00, 1, 0, 0, 10'h000, 0, 0, 0);
        add(0, 1, 8'h1C, 1, 0, 1, 10'h01C, 0, 0, 0);  // plain make
        add(0, 0, 8'h00, 1, 1, 0, 10'h000, 0, 0, 0);
        add(0, 1, 8'hE0, 1, 0, 0, 10'h000, 0, 0, 0);  // E0 F0 75
        add(0, 1, 8'hF0, 1, 0, 0, 10'h000, 0, 0, 0);
        add(0, 1, 8'h75, 1, 0, 1, 10'h375, 0, 0, 0);
        add(0, 0, 8'h00, 1, 1, 0, 10'h000, 0, 0, 0);
        add(0, 1, 8'hF0, 1, 0, 0, 10'h000, 0, 0, 0);  // F0 1C
        add(0, 1, 8'h1C, 1, 0, 1, 10'h21C, 0, 0, 0);
        add(0, 0, 8'h00, 1, 1, 0, 10'h000, 0, 0, 0);
        add(0, 1, 8'hE0, 1, 0, 0, 10'h000, 0, 0, 0);  // E0 F0 F0 -> discard
        add(0, 1, 8'hF0, 1, 0, 0, 10'h000, 0, 0, 0);
        add(0, 1, 8'hF0, 1, 0, 0, 10'h000, 0, 0, 0);
        add(0, 1, 8'h1C, 1, 0, 1, 10'h01C, 0, 0, 0);  // back in idle
        add(0, 0, 8'h00, 1, 1, 0, 10'h000, 0, 0, 0);
        add(0, 1, 8'h12, 1, 0, 1, 10'h012, 1, 0, 0);  // left shift
        add(0, 0, 8'h00, 1, 1, 0, 10'h000, 1, 0, 0);
        add(0, 1, 8'hE0, 1, 0, 0, 10'h000, 1, 0, 0);
        add(0, 1, 8'h12, 1, 0, 1, 10'h112, 1, 0, 0);  // fake shift
        add(0, 0, 8'h00, 1, 1, 0, 10'h000, 1, 0, 0);
        add(0, 1, 8'hF0, 1, 0, 0, 10'h000, 1, 0, 0);
        add(0, 1, 8'h12, 1, 0, 1, 10'h212, 0, 0, 0);  // shift release
        add(0, 0, 8'h00, 1, 1, 0, 10'h000, 0, 0, 0);
        add(0, 1, 8'h59, 1, 0, 1, 10'h059, 1, 0, 0);  // right shift
        add(0, 1, 8'hE0, 1, 1, 0, 10'h000, 1, 0, 0);
        add(0, 1, 8'hF0, 1, 0, 0, 10'h000, 1, 0, 0);
        add(0, 1, 8'h59, 1, 0, 1, 10'h359, 1, 0, 0);  // fake release keeps shift
        add(0, 1, 8'hF0, 1, 1, 0, 10'h000, 1, 0, 0);
        add(0, 1, 8'h59, 1, 0, 1, 10'h259, 0, 0, 0);
        add(0, 0, 8'h00, 1, 1, 0, 10'h000, 0, 0, 0);
        add(0, 1, 8'hF0, 1, 0, 0, 10'h000, 0, 0, 0);  // parity error after F0
        add(0, 1, 8'h1C, 0, 0, 0, 10'h000, 0, 1, 0);
        add(0, 0, 8'h00, 1, 0, 0, 10'h000, 0, 0, 0);
        add(0, 1, 8'h1C, 1, 0, 1, 10'h01C, 0, 0, 0);  // make, not break
        add(0, 0, 8'h00, 1, 1, 0, 10'h000, 0, 0, 0);
        add(0, 1, 8'hE0, 1, 0, 0, 10'h000, 0, 0, 0);  // parity error after E0
        add(0, 1, 8'h55, 0, 0, 0, 10'h000, 0, 1, 0);
        add(0, 1, 8'h75, 1, 0, 1, 10'h075, 0, 0, 0);
        add(0, 0, 8'h00, 1, 1, 0, 10'h000, 0, 0, 0);
        add(0, 1, 8'h15, 1, 0, 1, 10'h015, 0, 0, 0);  // overflow fill
        add(0, 1, 8'h16, 1, 0, 1, 10'h015, 0, 0, 0);
        add(0, 1, 8'h1E, 1, 0, 1, 10'h015, 0, 0, 0);
        add(0, 1, 8'h26, 1, 0, 1, 10'h015, 0, 0, 0);
        add(0, 1, 8'h25, 1, 0, 1, 10'h015, 0, 0, 1);  // dropped
        add(0, 0, 8'h00, 1, 1, 1, 10'h016, 0, 0, 1);
        add(0, 0, 8'h00, 1, 1, 1, 10'h01E, 0, 0, 1);
        add(0, 0, 8'h00, 1, 1, 1, 10'h026, 0, 0, 1);
        add(0, 0, 8'h00, 1, 1, 0, 10'h000, 0, 0, 1);
        add(1, 0, 8'h00, 1, 0, 0, 10'h000, 0, 0, 0);  // reset clears overflow
        add(0, 0, 8'h00, 1, 1, 0, 10'h000, 0, 0, 0);  // pop while empty
        add(0, 1, 8'h15, 1, 0, 1, 10'h015, 0, 0, 0);  // full + push + pop
        add(0, 1, 8'h16, 1, 0, 1, 10'h015, 0, 0, 0);
        add(0, 1, 8'h1E, 1, 0, 1, 10'h015, 0, 0, 0);
        add(0, 1, 8'h26, 1, 0, 1, 10'h015, 0, 0, 0);
        add(0, 1, 8'h1C, 1, 1, 1, 10'h016, 0, 0, 0);
        add(0, 0, 8'h00, 1, 1, 1, 10'h01E, 0, 0, 0);
        add(0, 0, 8'h00, 1, 1, 1, 10'h026, 0, 0, 0);
        add(0, 0, 8'h00, 1, 1, 1, 10'h01C, 0, 0, 0);
        add(0, 0, 8'h00, 1, 1, 0, 10'h000, 0, 0, 0);
        add(0, 1, 8'hE0, 1, 0, 0, 10'h000, 0, 0, 0);  // reset drops prefix
        add(1, 1, 8'h75, 1, 0, 0, 10'h000, 0, 0, 0);
        add(0, 1, 8'h75, 1, 0, 1, 10'h075, 0, 0, 0);
        add(0, 0, 8'h00, 1, 1, 0, 10'h000, 0, 0, 0);
        add(0, 1, 8'hAA, 1, 0, 0, 10'h000, 0, 0, 0);  // housekeeping bytes
        add(0, 1, 8'hFA, 1, 0, 0, 10'h000, 0, 0, 0);
        add(0, 1, 8'hE0, 1, 0, 0, 10'h000, 0, 0, 0);  // no tick -> hold
        add(0, 0, 8'h75, 1, 0, 0, 10'h000, 0, 0, 0);
        add(0, 1, 8'h75, 1, 0, 1, 10'h175, 0, 0, 0);
        add(0, 0, 8'h00, 1, 1, 0, 10'h000, 0, 0, 0);
        add(0, 1, 8'h15, 1, 0, 1, 10'h015, 0, 0, 0);  // shift on dropped push
        add(0, 1, 8'h16, 1, 0, 1, 10'h015, 0, 0, 0);
        add(0, 1, 8'h1E, 1, 0, 1, 10'h015, 0, 0, 0);
        add(0, 1, 8'h26, 1, 0, 1, 10'h015, 0, 0, 0);
        add(0, 1, 8'h12, 1, 0, 1, 10'h015, 1, 0, 1);
        add(1, 0, 8'h00, 1, 0, 0, 10'h000, 0, 0, 0);

        foreach (vecs[i]) begin
            drive(vecs[i].r, vecs[i].t, vecs[i].c, vecs[i].co, vecs[i].rd);
            chk("ev_valid", i, 10'(ev_valid), 10'(vecs[i].v));
            if (vecs[i].cd) chk("ev_data", i, ev_data, vecs[i].d);
            chk("shift_held", i, 10'(shift_held), 10'(vecs[i].sh));
            chk("frame_err", i, 10'(frame_err), 10'(vecs[i].fe));
            chk("overflow", i, 10'(overflow), 10'(vecs[i].ov));
        end

        // Single-entry FIFO with simultaneous push/pop walks pointers past the wrap
        drive(0, 1, 8'h2F, 1, 0);
        chk("wrap_head0", 1000, ev_data, 10'h02F);
        for (int k = 0; k < 10; k++) begin
            drive(0, 1, 8'h30 + 8'(k), 1, 1);
            chk("wrap_valid", 1001 + k, 10'(ev_valid), 10'h001);
            chk("wrap_head", 1001 + k, ev_data, 10'h030 + 10'(k));
            chk("wrap_ovf", 1001 + k, 10'(overflow), 10'h000);
        end
        drive(0, 0, 8'h00, 1, 1);
        chk("wrap_empty", 1011, 10'(ev_valid), 10'h000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ps2_scan_decoder.md
PS2_SCAN_DECODER -- requirements
Module: ps2_scan_decoder

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning the number of event FIFO entries (power of two, minimum 2).
REQ-002 SHALL have port clk, input, 1, the single clock; every register is clocked on its rising edge.
REQ-003 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-004 SHALL have port code, input, 8, the received PS/2 byte from the keyboard receiver, valid only in the tick cycle.
REQ-005 SHALL have port tick, input, 1, a one-cycle strobe meaning a new byte is on code.
REQ-006 SHALL have port correct, input, 1, the receiver's parity-OK flag, sampled only in the tick cycle.
REQ-007 SHALL have port rd_en, input, 1, consumer pop request.
REQ-008 SHALL have port ev_data, output, 10, the FIFO head as {released, extended, code[7:0]}.
REQ-009 SHALL have port ev_valid, output, 1, high when the FIFO is non-empty.
REQ-010 SHALL have port shift_held, output, 1, high while left or right shift is held.
REQ-011 SHALL have port frame_err, output, 1, a one-cycle pulse when a byte is discarded for bad parity.
REQ-012 SHALL have port overflow, output, 1, sticky flag for an event dropped on a full FIFO.

Function
REQ-013 SHALL decode prefixes with four states: IDLE, EXT (after E0), BRK (after F0), EXT_BRK (after E0 F0).
REQ-014 SHALL act only in cycles where tick=1; with tick=0 the state and all flags hold.
REQ-015 In IDLE, tick with E0 -> EXT; F0 -> BRK; 00, AA, EE, FA, FC, FE or FF -> discard and stay IDLE; any other byte -> push {0,0,code} and stay IDLE.
REQ-016 In EXT: F0 -> EXT_BRK; E0 -> stay EXT; any other byte -> push {0,1,code} and go to IDLE.
REQ-017 In BRK: any byte other than E0/F0 -> push {1,0,code} and go to IDLE; E0 or F0 -> discard and go to IDLE.
REQ-018 In EXT_BRK: any byte other than E0/F0 -> push {1,1,code} and go to IDLE; E0 or F0 -> discard and go to IDLE.
REQ-019 On tick with correct=0: discard the byte, go to IDLE from any state, pulse frame_err for exactly one cycle, and push nothing.
REQ-020 A pushed event SHALL appear on ev_data/ev_valid in the cycle after its tick (one-cycle latency).
REQ-021 The FIFO SHALL be first-word-fall-through: ev_data always shows the oldest entry; rd_en with ev_valid=1 removes it at the clock edge.
REQ-022 rd_en while empty SHALL be ignored; ev_data is don't-care while ev_valid=0.
REQ-023 A push into a full FIFO SHALL drop the new event, keep the stored events, and set overflow.
REQ-024 overflow SHALL clear only on rst.
REQ-025 A push and a pop in the same cycle SHALL both take effect, including when the FIFO is full; the count is unchanged and no overflow occurs.
REQ-026 Read and write pointers SHALL wrap modulo DEPTH; the count SHALL range 0..DEPTH.
REQ-027 Shift tracking SHALL update only on a non-extended event: code 12 sets lshift, code 59 sets rshift, and the matching release clears it.
REQ-028 Extended 12/59 events (fake shifts) SHALL NOT affect shift tracking.
REQ-029 shift_held SHALL equal lshift OR rshift, registered and updated in the same cycle the event is pushed (also when the push is dropped on overflow).

Reset
REQ-030 SHALL, while rst=1 at a clock edge, set state=IDLE, empty the FIFO, set ev_valid=0, ev_data=0, shift_held=0, frame_err=0 and overflow=0, and ignore tick and rd_en.
REQ-031 Reset asserted between a prefix byte and its code byte SHALL discard the pending prefix.

Verification
REQ-032 Bytes 1C -> ev_data=01C, ev_valid=1 one cycle after tick; rd_en -> ev_valid=0.
REQ-033 Bytes E0 F0 75 -> exactly one event 375; F0 1C -> 21C; E0 with F0 as the third byte -> nothing pushed, state IDLE.
REQ-034 Bytes 12, then E0 12, then F0 12 -> shift_held=1 after the first 12, still 1 after E0 12, and 0 after F0 12.
REQ-035 Bytes F0 then 1C with correct=0 on 1C -> frame_err pulse, no event; a following 1C -> 01C (make, not break).
REQ-036 DEPTH+1 make codes 15,16,1E,26,25 with no reads (DEPTH=4) -> four events 015..026 retained, 025 dropped, overflow=1 until rst.
REQ-037 FIFO full plus tick 1C and rd_en in the same cycle -> count stays 4, head advances, 01C is stored last, overflow stays 0.
